// File: rtl/route_out_downsizer.sv
`timescale 1ns/1ps
// Purpose: splits each wide input word into IN_WIDTH/OUT_WIDTH narrow beats, least-significant slice first.
// Latency: a word accepted at edge N presents slice 0 in cycle N+1; one beat per cycle while m_out_tready is high.
// Backpressure: an active word plus one pending word are held; s_in_tready drops while the pending slot is full.
// Optional tlast generation every FRAME_WORDS words: define ROUTE_OUT_DOWNSIZER_TLAST_EN.
module route_out_downsizer #(
  parameter int IN_WIDTH    = 1536,
  parameter int OUT_WIDTH   = 128,
  parameter int FRAME_WORDS = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_WIDTH-1:0]  s_in_tdata,
  input  logic                 s_in_tvalid,
  output logic                 s_in_tready,
  output logic [OUT_WIDTH-1:0] m_out_tdata,
  output logic                 m_out_tvalid,
  input  logic                 m_out_tready,
  output logic                 m_out_tlast
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int BW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(RATIO - 1);

  // Reject widths that do not split into whole beats, and empty frames.
  generate
    if ((IN_WIDTH % OUT_WIDTH) != 0 || IN_WIDTH < OUT_WIDTH) begin : g_bad_ratio
      $error("route_out_downsizer: IN_WIDTH must be a multiple of OUT_WIDTH");
    end
    if (FRAME_WORDS < 1) begin : g_bad_frame
      $error("route_out_downsizer: FRAME_WORDS must be at least 1");
    end
  endgenerate

  // Active word being sliced and the word waiting behind it.
  logic [IN_WIDTH-1:0] act_data;
  logic                act_valid;
  logic [IN_WIDTH-1:0] pend_data;
  logic                pend_valid;
  logic [BW-1:0]       beat_idx;
  logic                rdy_en;

  logic out_hs;
  logic in_hs;
  logic last_beat;
  logic word_done;
  logic load_act;
  logic load_pend;
  logic promote;

  // s_in_tready looks only at local state, never at m_out_tready.
  assign s_in_tready  = rdy_en & ~pend_valid;
  assign m_out_tvalid = act_valid;

  assign out_hs    = act_valid & m_out_tready;
  assign in_hs     = s_in_tvalid & s_in_tready;
  assign last_beat = (beat_idx == LAST_IDX);
  assign word_done = out_hs & last_beat;

  // A new word goes straight to act only when act is empty or freeing now
  // (pend is necessarily empty whenever an input handshake happens).
  assign load_act  = in_hs & (~act_valid | word_done);
  assign load_pend = in_hs & act_valid & ~word_done;
  assign promote   = word_done & pend_valid;

  // Select the current narrow slice of the active word.
  always_comb begin
    m_out_tdata = act_data[beat_idx*OUT_WIDTH +: OUT_WIDTH];
  end

  // Control state: valid flags, beat index and the post-reset ready enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_valid  <= 1'b0;
      pend_valid <= 1'b0;
      beat_idx   <= '0;
      rdy_en     <= 1'b0;
    end else begin
      rdy_en <= 1'b1;

      if (word_done) begin
        beat_idx  <= '0;
        act_valid <= pend_valid | in_hs;
      end else if (out_hs) begin
        beat_idx <= beat_idx + 1'b1;
      end else if (load_act) begin
        act_valid <= 1'b1;
        beat_idx  <= '0;
      end

      if (promote) begin
        pend_valid <= 1'b0;
      end else if (load_pend) begin
        pend_valid <= 1'b1;
      end
    end
  end

  // Data registers; cleared on reset so no stale beat is ever presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_data  <= '0;
      pend_data <= '0;
    end else begin
      if (promote) begin
        act_data <= pend_data;
      end else if (load_act) begin
        act_data <= s_in_tdata;
      end
      if (load_pend) begin
        pend_data <= s_in_tdata;
      end
    end
  end

`ifdef ROUTE_OUT_DOWNSIZER_TLAST_EN
  localparam int FW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [FW-1:0] FRM_LAST = FW'(FRAME_WORDS - 1);

  logic [FW-1:0] frm_cnt;

  // Count completed words within the frame, wrapping at the frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_cnt <= '0;
    end else if (word_done) begin
      frm_cnt <= (frm_cnt == FRM_LAST) ? '0 : frm_cnt + 1'b1;
    end
  end

  assign m_out_tlast = act_valid & last_beat & (frm_cnt == FRM_LAST);
`else
  assign m_out_tlast = 1'b0;
`endif

endmodule

// File: tb/tb_route_out_downsizer.sv
`timescale 1ns/1ps
// Bench for route_out_downsizer: queue-of-beats reference model checked every cycle,
// plus literal expectations for single word, back-to-back, backpressure, tlast and reset.
// Ready pattern is selected per phase; input words are random or slice-numbered.
module tb_route_out_downsizer;

  localparam int IW = 1536;
  localparam int OW = 128;
  localparam int R  = IW / OW;
  localparam int FW = 10;
`ifdef ROUTE_OUT_DOWNSIZER_TLAST_EN
  localparam bit TLAST_EN = 1'b1;
`else
  localparam bit TLAST_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IW-1:0] s_in_tdata;
  logic          s_in_tvalid;
  logic          s_in_tready;
  logic [OW-1:0] m_out_tdata;
  logic          m_out_tvalid;
  logic          m_out_tready;
  logic          m_out_tlast;

  route_out_downsizer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .FRAME_WORDS(FW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_in_tdata   (s_in_tdata),
    .s_in_tvalid  (s_in_tvalid),
    .s_in_tready  (s_in_tready),
    .m_out_tdata  (m_out_tdata),
    .m_out_tvalid (m_out_tvalid),
    .m_out_tready (m_out_tready),
    .m_out_tlast  (m_out_tlast)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: expected beats in emission order, with their tlast flag.
  logic [OW-1:0] exp_q[$];
  bit            lst_q[$];
  int            wcnt;
  int            bcnt;
  bit            armed;
  bit            stall_p;
  logic [OW-1:0] dat_p;
  logic          last_p;
  int            held;

  // Observed output beats, their handshake edge, and tlast beat numbers.
  logic [OW-1:0] obs_q[$];
  int            edge_q[$];
  int            tl_q[$];

  int rmode = 0;
  int acc_edge = 0;

  // Downstream ready generator: 0 = always, 1 = 1,0,0,1 pattern, 2 = random.
  always @(posedge clk) begin
    #1;
    case (rmode)
      1:       m_out_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      2:       m_out_tready = 1'($urandom_range(0, 1));
      default: m_out_tready = 1'b1;
    endcase
  end

  // Compare process: check outputs mid-cycle, then advance the model by the
  // handshakes that will occur at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_tvalid", 128'(m_out_tvalid), 128'(0));
      chk("rst_tready", 128'(s_in_tready), 128'(0));
      chk("rst_tdata", 128'(m_out_tdata), 128'(0));
      chk("rst_tlast", 128'(m_out_tlast), 128'(0));
      exp_q.delete();
      lst_q.delete();
      tl_q.delete();
      wcnt    = 0;
      bcnt    = 0;
      armed   = 1'b0;
      stall_p = 1'b0;
    end else begin
      held = (exp_q.size() + R - 1) / R;
      chk("tvalid", 128'(m_out_tvalid), 128'(exp_q.size() != 0));
      chk("tready", 128'(s_in_tready), 128'(armed && held < 2));
      if (exp_q.size() != 0) begin
        chk("tdata", 128'(m_out_tdata), 128'(exp_q[0]));
        chk("tlast", 128'(m_out_tlast), 128'(lst_q[0]));
      end
      if (stall_p) begin
        chk("hold_valid", 128'(m_out_tvalid), 128'(1));
        chk("hold_data", 128'(m_out_tdata), 128'(dat_p));
        chk("hold_last", 128'(m_out_tlast), 128'(last_p));
      end
      stall_p = m_out_tvalid & ~m_out_tready;
      dat_p   = m_out_tdata;
      last_p  = m_out_tlast;
      if (m_out_tvalid && m_out_tready) begin
        bcnt++;
        obs_q.push_back(m_out_tdata);
        edge_q.push_back(cyc + 1);
        if (m_out_tlast) tl_q.push_back(bcnt);
        if (exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          void'(lst_q.pop_front());
        end
      end
      if (s_in_tvalid && s_in_tready) begin
        for (int k = 0; k < R; k++) begin
          exp_q.push_back(s_in_tdata[k*OW +: OW]);
          lst_q.push_back(TLAST_EN && (k == R - 1) && ((wcnt % FW) == FW - 1));
        end
        wcnt++;
      end
      armed = 1'b1;
    end
  end

  function automatic logic [IW-1:0] slice_word();
    logic [IW-1:0] w;
    w = '0;
    for (int k = 0; k < R; k++) w[k*OW +: OW] = OW'(k + 1);
    return w;
  endfunction

  function automatic logic [IW-1:0] rand_word();
    logic [IW-1:0] w;
    for (int i = 0; i < IW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Offer one word until accepted; optionally leave valid asserted afterwards.
  task automatic send_word(input logic [IW-1:0] w, input bit keep);
    int n;
    bit hs;
    n = 0;
    s_in_tdata  = w;
    s_in_tvalid = 1'b1;
    do begin
      @(negedge clk);
      hs = s_in_tready;
      @(posedge clk);
      #1;
      n++;
    end while (!hs && n < 1000);
    chk("accept_timeout", 128'(hs), 128'(1));
    acc_edge = cyc;
    if (!keep) s_in_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && !m_out_tvalid) break;
      @(posedge clk);
      #1;
    end
    chk("drain_timeout", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [IW-1:0] ws[3];
  logic [IW-1:0] sw;

  initial begin
    s_in_tvalid  = 1'b0;
    s_in_tdata   = '0;
    m_out_tready = 1'b1;
    rst_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tready", 128'(s_in_tready), 128'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("release_tready", 128'(s_in_tready), 128'(1));

    // Single word, slices 1..12, full-rate output.
    obs_q.delete();
    edge_q.delete();
    sw = slice_word();
    send_word(sw, 1'b0);
    wait_drain();
    chk("sw_count", 128'(obs_q.size()), 128'(12));
    if (obs_q.size() >= 12) begin
      for (int k = 0; k < 12; k++) chk("sw_beat", 128'(obs_q[k]), 128'(k + 1));
      chk("sw_latency", 128'(edge_q[0]), 128'(acc_edge + 1));
      chk("sw_contig", 128'(edge_q[11] - edge_q[0]), 128'(11));
    end
    chk("sw_idle_valid", 128'(m_out_tvalid), 128'(0));

    // Back-to-back: three words offered continuously, no output bubble.
    obs_q.delete();
    edge_q.delete();
    for (int i = 0; i < 3; i++) ws[i] = rand_word();
    for (int i = 0; i < 3; i++) send_word(ws[i], 1'b1);
    s_in_tvalid = 1'b0;
    wait_drain();
    chk("b2b_count", 128'(obs_q.size()), 128'(36));
    if (obs_q.size() >= 36) begin
      chk("b2b_contig", 128'(edge_q[35] - edge_q[0]), 128'(35));
      for (int i = 0; i < 36; i++)
        chk("b2b_order", 128'(obs_q[i]), 128'(ws[i/12][(i%12)*OW +: OW]));
    end

    // Backpressure: ready pattern 1,0,0,1 over two words.
    obs_q.delete();
    edge_q.delete();
    rmode = 1;
    for (int i = 0; i < 2; i++) ws[i] = rand_word();
    for (int i = 0; i < 2; i++) send_word(ws[i], 1'b1);
    s_in_tvalid = 1'b0;
    wait_drain();
    rmode = 0;
    chk("bp_count", 128'(obs_q.size()), 128'(24));
    if (obs_q.size() >= 24) begin
      for (int i = 0; i < 24; i++)
        chk("bp_order", 128'(obs_q[i]), 128'(ws[i/12][(i%12)*OW +: OW]));
    end

    // Random ready and random input gaps.
    rmode = 2;
    for (int i = 0; i < 30; i++) begin
      send_word(rand_word(), 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_drain();
    rmode = 0;

    // tlast: 20 words at full rate after a fresh reset.
    pulse_reset();
    for (int i = 0; i < 20; i++) send_word(rand_word(), 1'b1);
    s_in_tvalid = 1'b0;
    wait_drain();
    chk("tl_count", 128'(tl_q.size()), 128'(TLAST_EN ? 2 : 0));
    if (TLAST_EN && tl_q.size() == 2) begin
      chk("tl_first", 128'(tl_q[0]), 128'(120));
      chk("tl_second", 128'(tl_q[1]), 128'(240));
    end

    // Reset in the middle of a word after its fifth beat.
    obs_q.delete();
    send_word(rand_word(), 1'b0);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (obs_q.size() >= 5) break;
    end
    chk("mid_beats", 128'(obs_q.size()), 128'(5));
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(m_out_tvalid), 128'(0));
    chk("mid_rst_ready", 128'(s_in_tready), 128'(0));
    chk("mid_rst_data", 128'(m_out_tdata), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_release_ready", 128'(s_in_tready), 128'(1));
    chk("mid_release_valid", 128'(m_out_tvalid), 128'(0));
    obs_q.delete();
    send_word(slice_word(), 1'b0);
    wait_drain();
    chk("mid_count", 128'(obs_q.size()), 128'(12));
    if (obs_q.size() >= 12) begin
      for (int k = 0; k < 12; k++) chk("mid_beat", 128'(obs_q[k]), 128'(k + 1));
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
